// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the two-requester serial add/subtract arbiter:
// FSM encoding, requester count, default operand width and small helpers.
package serial_add_arbiter_pkg;

  localparam int NREQ      = 2;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [NREQ-1:0] req_onehot(input logic id);
    logic [NREQ-1:0] v;
    v     = {NREQ{1'b0}};
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/serial_add_arbiter_core.sv
// Bit-serial ripple adder: operand shift registers, carry flop, result
// accumulator and a down-counter flagging the final shift.
module serial_add_core
  import serial_add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             last_o,
  output logic [WIDTH:0]   result_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_s;

  // Next-state for load / shift / hold of the serial datapath.
  always_comb begin
    s_s   = a_q[0] ^ b_q[0] ^ c_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = {WIDTH{1'b0}};
      c_d   = cin_i;
      cnt_d = CW'(WIDTH);
    end else if (shift_i) begin
      a_d   = {1'b0, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      acc_d = {s_s, acc_q[WIDTH-1:1]};
      c_d   = maj3(a_q[0], b_q[0], c_q);
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
      acc_q <= {WIDTH{1'b0}};
      c_q   <= 1'b0;
      cnt_q <= {CW{1'b0}};
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

  // Once the last shift has landed, acc holds all sum bits and c the carry out.
  assign last_o   = shift_i && (cnt_q == CW'(1));
  assign result_o = {c_q, acc_q};

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter sharing one serial add/subtract core between two
// requesters; returns a registered result with a one-cycle ack per requester.
module serial_add_arbiter
  import serial_add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             Reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             sub0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             sub1,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             grant_id
);

  state_t           state_q;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH:0]   sum_q;
  logic             busy_q;
  logic             grant_id_q;

  logic             winner_s;
  logic [WIDTH-1:0] op_x_s;
  logic [WIDTH-1:0] op_y_s;
  logic             op_sub_s;
  logic [WIDTH-1:0] op_b_s;
  logic             load_s;
  logic             shift_s;
  logic             last_s;
  logic [WIDTH:0]   core_result_s;

  // Winner selection: a tie goes to whoever was not served last.
  always_comb begin
    winner_s = grant_id_q;
    case (req)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = ~grant_id_q;
      default: winner_s = grant_id_q;
    endcase
  end

  // Operand mux; subtraction is x + ~y + 1 with the +1 entering as carry-in.
  always_comb begin
    op_x_s   = winner_s ? x1 : x0;
    op_y_s   = winner_s ? y1 : y0;
    op_sub_s = winner_s ? sub1 : sub0;
    op_b_s   = op_sub_s ? ~op_y_s : op_y_s;
    load_s   = (state_q == ST_IDLE) && (req != {NREQ{1'b0}});
    shift_s  = (state_q == ST_RUN);
  end

  serial_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i    (clock),
    .rst_ni   (Reset_n),
    .load_i   (load_s),
    .shift_i  (shift_s),
    .a_i      (op_x_s),
    .b_i      (op_b_s),
    .cin_i    (op_sub_s),
    .last_o   (last_s),
    .result_o (core_result_s)
  );

  // Sequencing FSM with registered result, ack, busy and grant pointer.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= {NREQ{1'b0}};
      sum_q      <= {(WIDTH + 1){1'b0}};
      busy_q     <= 1'b0;
      grant_id_q <= 1'b1;
    end else begin
      ack_q <= {NREQ{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (load_s) begin
            grant_id_q <= winner_s;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          sum_q   <= core_result_s;
          ack_q   <= req_onehot(grant_id_q);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign sum      = sum_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed plus randomized bench for serial_add_arbiter, checked against a
// plain-arithmetic result model and a round-robin winner model.
module tb_serial_add_arbiter;

  localparam int W = 4;

  logic         clock;
  logic         Reset_n;
  logic [1:0]   req;
  logic [W-1:0] x0, y0, x1, y1;
  logic         sub0, sub1;
  logic [1:0]   ack;
  logic [W:0]   sum;
  logic         busy;
  logic         grant_id;

  int   checks;
  int   passes;
  logic last_win;
  int   acks;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clock    (clock),
    .Reset_n  (Reset_n),
    .req      (req),
    .x0       (x0),
    .y0       (y0),
    .sub0     (sub0),
    .x1       (x1),
    .y1       (y1),
    .sub1     (sub1),
    .ack      (ack),
    .sum      (sum),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int x, input int y, input logic s);
    return s ? (x + (1 << W) - y) : (x + y);
  endfunction

  function automatic logic pick(input logic [1:0] r, input logic last);
    if (r == 2'b01) return 1'b0;
    else if (r == 2'b10) return 1'b1;
    else return ~last;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  // Starts at a negedge with the FSM idle; returns at the negedge of the ack cycle.
  task automatic op(input logic [1:0] r, input logic [1:0] mid,
                    input logic [W-1:0] ax0, input logic [W-1:0] ay0, input logic as0,
                    input logic [W-1:0] ax1, input logic [W-1:0] ay1, input logic as1);
    logic win;
    int   expv;
    req  = r;
    x0 = ax0; y0 = ay0; sub0 = as0;
    x1 = ax1; y1 = ay1; sub1 = as1;
    win  = pick(r, last_win);
    expv = win ? model(int'(ax1), int'(ay1), as1) : model(int'(ax0), int'(ay0), as0);
    @(negedge clock);
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_id", 32'(grant_id), 32'(win));
    check("ack_clear", 32'(ack), 32'd0);
    last_win = win;
    x0 = rnd_op(); y0 = rnd_op(); sub0 = 1'($urandom_range(0, 1));
    x1 = rnd_op(); y1 = rnd_op(); sub1 = 1'($urandom_range(0, 1));
    for (int k = 1; k <= W; k++) begin
      @(negedge clock);
      if (k == 2) req = mid;
      check("ack_early", 32'(ack), 32'd0);
    end
    @(negedge clock);
    check("ack", 32'(ack), win ? 32'd2 : 32'd1);
    check("sum", 32'(sum), 32'(expv));
  endtask

  initial begin
    checks = 0;
    passes = 0;
    last_win = 1'b1;
    Reset_n = 1'b0;
    req = 2'b00;
    x0 = '0; y0 = '0; sub0 = 1'b0;
    x1 = '0; y1 = '0; sub1 = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd1);
    Reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic add, then add with carry out.
    op(2'b01, 2'b01, 4'd5, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0);
    op(2'b01, 2'b01, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0);
    req = 2'b00;
    @(negedge clock);
    check("ack_drop", 32'(ack), 32'd0);

    // Reset two cycles into an operation abandons it.
    req = 2'b01; x0 = 4'd7; y0 = 4'd6; sub0 = 1'b0;
    repeat (3) @(negedge clock);
    Reset_n = 1'b0;
    req = 2'b00;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd1);
    last_win = 1'b1;
    @(negedge clock);
    Reset_n = 1'b1;
    acks = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (ack != 2'b00) acks++;
    end
    check("no_ack_after_rst", 32'(acks), 32'd0);

    // Simultaneous requests, each dropping on its own ack.
    op(2'b11, 2'b11, 4'd1, 4'd2, 1'b0, 4'd9, 4'd8, 1'b0);
    op(2'b10, 2'b10, 4'd1, 4'd2, 1'b0, 4'd9, 4'd8, 1'b0);
    req = 2'b00;
    @(negedge clock);
    check("rr_final_grant", 32'(grant_id), 32'd1);

    // Subtraction with and without borrow.
    op(2'b10, 2'b10, 4'd0, 4'd0, 1'b0, 4'd3, 4'd5, 1'b1);
    op(2'b10, 2'b10, 4'd0, 4'd0, 1'b0, 4'd9, 4'd4, 1'b1);
    req = 2'b00;
    @(negedge clock);

    // req0 held; req1 joins mid-run; then alternation under contention.
    op(2'b01, 2'b01, 4'd2, 4'd3, 1'b0, 4'd6, 4'd1, 1'b1);
    op(2'b01, 2'b01, 4'd4, 4'd4, 1'b1, 4'd6, 4'd1, 1'b1);
    op(2'b01, 2'b11, 4'd8, 4'd7, 1'b0, 4'd6, 4'd1, 1'b1);
    op(2'b11, 2'b11, 4'd8, 4'd7, 1'b0, 4'd6, 4'd1, 1'b1);
    op(2'b11, 2'b11, 4'd12, 4'd1, 1'b1, 4'd0, 4'd15, 1'b1);
    op(2'b11, 2'b01, 4'd12, 4'd1, 1'b1, 4'd11, 4'd10, 1'b0);
    req = 2'b00;
    @(negedge clock);

    // Randomized requests, operands and mid-run request changes.
    for (int i = 0; i < 24; i++) begin
      op(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
         rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
         rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    end
    req = 2'b00;
    repeat (3) @(negedge clock);
    check("end_idle_busy", 32'(busy), 32'd0);
    check("end_idle_ack", 32'(ack), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
Shares one bit-serial add/subtract datapath between two requesters. Round-robin arbitration picks a requester, loads its operands into the serial core, and sequences WIDTH shift cycles. It then returns the (WIDTH+1)-bit result with a one-cycle per-requester ack. It sits between the lab-level operand sources and the serial adder datapath. This replaces per-requester adder copies and ad-hoc Start/Done wiring.

Parameters:
WIDTH, 4, operand width in bits (>=2); result is WIDTH+1 bits.

Ports:
clock  input  1  single clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
req  input  2  req[i] high = requester i wants an operation; level, sampled only in IDLE.
x0, y0  input  WIDTH  requester 0 operands; captured at the grant edge only.
sub0  input  1  requester 0 op: 0 = x+y, 1 = x-y.
x1, y1  input  WIDTH  requester 1 operands; captured at the grant edge only.
sub1  input  1  requester 1 op select.
ack  output  2  one-cycle pulse on ack[i] when requester i's result is valid.
sum  output  WIDTH+1  registered result: {carry_out, WIDTH sum bits}; holds until the next completion.
busy  output  1  high in RUN and DONE.
grant_id  output  1  requester currently or last served.

Behaviour:
- Reset (Reset_n low, async) values:
  - state=IDLE; ack=0; sum=0; busy=0; grant_id=1 (so requester 0 wins the first tie).
  - Core shift registers, carry FF and counter all cleared.
- Reset mid-operation: the operation is abandoned and no ack is ever produced for it. After release, the FSM restarts in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req==0: stay in IDLE.
  - Exactly one req bit set: grant that requester.
  - Both set: grant the requester != grant_id (round-robin).
  - On the grant edge:
    - grant_id <= winner.
    - Core loads x, the operand y (or ~y if sub), and carry FF = sub.
    - Counter <= WIDTH.
    - state <= RUN.
- RUN:
  - Each edge shifts one bit LSB-first.
  - s = a^b^c; carry <= majority(a,b,c); s is shifted into the accumulator MSB.
  - Counter decrements each edge. On the edge where the counter reaches 0, state <= DONE and sum <= {carry_out, acc}.
- DONE:
  - ack[grant_id]=1 for exactly this one cycle; sum is valid.
  - Next edge: state <= IDLE.
- Latency: the grant edge is E0; ack is high in the cycle after edge E(WIDTH+1). Minimum spacing between consecutive grants is WIDTH+2 cycles.
- Arithmetic:
  - Add: sum = x+y, no wrap, MSB is the carry.
  - Sub: sum[WIDTH-1:0] = (x-y) mod 2^WIDTH; sum[WIDTH] = 1 means no borrow (x>=y).
- Requests:
  - A requester seeing ack must drop req in that cycle, or it is treated as a new request in the next IDLE.
  - req dropping during RUN does not abort; the ack is still pulsed.
  - Operand changes after the grant edge are ignored.
- sum and ack are driven from flops; there are no combinational paths from req or operands to outputs.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE, ST_RUN, ST_DONE.
  - NREQ=2.
  - Default WIDTH.
- Sub-module serial_add_core(WIDTH): accumulator/operand shift registers, carry FF, down-counter, load/shift inputs, last-shift indication.
- The arbiter contains the FSM, round-robin pointer, operand mux, and result/ack registers.

Test Plan:
1. WIDTH=4, req=01, x0=5, y0=3, sub0=0 -> busy from E0; ack=01 exactly in the cycle after E5; sum=5'b01000; ack low in the next cycle.
2. req=01, x0=15, y0=15 -> sum=5'b11110 (30); carry bit set.
3. After reset, req=11 (x0=1,y0=2; x1=9,y1=8), each requester drops req on its ack -> ack0 first with sum=3, then ack1 with sum=17 (5'b10001); grant_id=1 at the end.
4. req=10, x1=3, y1=5, sub1=1 -> sum=5'b01110 (borrow, -2 mod 16); then x1=9, y1=4, sub1=1 -> sum=5'b10101.
5. Reset_n pulsed low 2 cycles after a grant -> immediately state IDLE, busy=0, ack=0, sum=0; no ack after release; a fresh request then completes correctly.
6. req0 held high continuously, then req1 raised mid-RUN -> req0 served every 6 cycles until req1 rises; next grant goes to req1, then alternation 0,1,0; no ack is ever missed or duplicated.
